// File: rtl/keypad_scan.sv
// Row-scanning 4x3 keypad front end: synchronizes and debounces the column returns and accepts one key per press.
// Optional macro KEYPAD_CELL_ONLY_EN restricts accepted keys to board cells 1..9.
module keypad_scan #(
    parameter int SCAN_DIV       = 25000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] key_col,
    output logic [3:0] key_row,
    output logic [3:0] key_data,
    output logic       key_valid,
    output logic       key_busy
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0] DEB_TARGET = 4'(DEBOUNCE_SCANS);

    logic [2:0]       sync1_q, sync1_d;
    logic [2:0]       sync2_q, sync2_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       row_q, row_d;
    logic [11:0]      snap_q, snap_d;
    logic [11:0]      prev_snap_q, prev_snap_d;
    logic [3:0]       stable_cnt_q, stable_cnt_d;
    logic [3:0]       key_data_q, key_data_d;
    logic             key_valid_q, key_valid_d;
    logic             key_busy_q, key_busy_d;

    logic             sample;
    logic             scan_end;
    logic [11:0]      snap_full;
    logic [3:0]       stable_new;
    logic             one_hot;
    logic             code_ok;

    function automatic logic [3:0] key_code(input logic [11:0] s);
        logic [3:0] c;
        c = 4'hF;
        for (int i = 0; i < 12; i++) begin
            if (s[i]) begin
                if (i < 9)       c = 4'(i + 1);
                else if (i == 9) c = 4'd10;
                else if (i == 10) c = 4'd0;
                else             c = 4'd11;
            end
        end
        return c;
    endfunction

    always_comb begin
        sync1_d      = key_col;
        sync2_d      = sync1_q;
        div_d        = div_q;
        row_d        = row_q;
        snap_d       = snap_q;
        prev_snap_d  = prev_snap_q;
        stable_cnt_d = stable_cnt_q;
        key_data_d   = key_data_q;
        key_valid_d  = 1'b0;
        key_busy_d   = key_busy_q;

        sample   = (div_q == DIV_LAST);
        scan_end = sample && (row_q == 2'd3);

        // Snapshot as it stands once the current row's sample is merged in.
        snap_full = snap_q;
        case (row_q)
            2'd0:    snap_full[2:0]  = sync2_q;
            2'd1:    snap_full[5:3]  = sync2_q;
            2'd2:    snap_full[8:6]  = sync2_q;
            default: snap_full[11:9] = sync2_q;
        endcase

        stable_new = (snap_full == prev_snap_q)
                   ? ((stable_cnt_q == 4'd15) ? 4'd15 : stable_cnt_q + 4'd1)
                   : 4'd1;
        one_hot    = (snap_full != 12'd0) && ((snap_full & (snap_full - 12'd1)) == 12'd0);
`ifdef KEYPAD_CELL_ONLY_EN
        code_ok    = |snap_full[8:0];
`else
        code_ok    = 1'b1;
`endif

        if (sample) begin
            div_d  = '0;
            row_d  = row_q + 2'd1;
            snap_d = snap_full;
        end else begin
            div_d  = div_q + DIV_W'(1);
        end

        if (scan_end) begin
            prev_snap_d  = snap_full;
            stable_cnt_d = stable_new;
            if (stable_new == DEB_TARGET) begin
                // Non-cell keys under the cell-only build still lock out other keys until release.
                if (one_hot && !key_busy_q) begin
                    key_busy_d = 1'b1;
                    if (code_ok) begin
                        key_valid_d = 1'b1;
                        key_data_d  = key_code(snap_full);
                    end
                end else if (snap_full == 12'd0) begin
                    key_busy_d = 1'b0;
                end
            end
        end

        key_row = 4'd1 << row_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 3'd0;
            sync2_q      <= 3'd0;
            div_q        <= '0;
            row_q        <= 2'd0;
            snap_q       <= 12'd0;
            prev_snap_q  <= 12'd0;
            stable_cnt_q <= 4'd0;
            key_data_q   <= 4'hF;
            key_valid_q  <= 1'b0;
            key_busy_q   <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            div_q        <= div_d;
            row_q        <= row_d;
            snap_q       <= snap_d;
            prev_snap_q  <= prev_snap_d;
            stable_cnt_q <= stable_cnt_d;
            key_data_q   <= key_data_d;
            key_valid_q  <= key_valid_d;
            key_busy_q   <= key_busy_d;
        end
    end

    assign key_data  = key_data_q;
    assign key_valid = key_valid_q;
    assign key_busy  = key_busy_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: scenario table, hand-written corner sequences and randomized keypad activity
// compared every cycle against a scan-level reference model.
module tb_keypad_scan;

    localparam int SD   = 4;
    localparam int DB   = 2;
    localparam int SCAN = 4 * SD;
    localparam int NT   = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] key_col = 3'd0;
    logic [3:0] key_row;
    logic [3:0] key_data;
    logic       key_valid;
    logic       key_busy;

    keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_col   (key_col),
        .key_row   (key_row),
        .key_data  (key_data),
        .key_valid (key_valid),
        .key_busy  (key_busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: history of applied column values and completed scan snapshots.
    logic [2:0]  hist[$];
    logic [11:0] scans[$];
    int          m_t = 0;
    logic [3:0]  m_data = 4'hF;
    logic        m_valid = 1'b0;
    logic        m_busy = 1'b0;

    int cyc = 0;
    int last_strobe = 0;
    bit have_strobe = 0;
    int phase_strobes = 0;

    typedef struct {
        logic        rst_first;
        logic [11:0] mask;
        int          scans;
        int          exp_strobes;
        logic [3:0]  exp_data;
        logic        exp_busy;
    } vec_t;
    vec_t tbl[NT];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0] ref_code(input int idx);
        if (idx < 9) return 4'(idx + 1);
        if (idx == 9) return 4'd10;
        if (idx == 10) return 4'd0;
        return 4'd11;
    endfunction

    function automatic logic [2:0] sync_at(input int edge_idx);
        if (edge_idx < 2) return 3'd0;
        return hist[edge_idx - 2];
    endfunction

    task automatic model_step(input logic [2:0] col, input logic r);
        logic [11:0] snap;
        int run, idx, stable;
        if (r) begin
            hist.delete();
            scans.delete();
            m_t = 0;
            m_data = 4'hF;
            m_valid = 1'b0;
            m_busy = 1'b0;
            return;
        end
        hist.push_back(col);
        m_valid = 1'b0;
        if ((m_t % SCAN) == SCAN - 1) begin
            snap = 12'd0;
            for (int rr = 0; rr < 4; rr++)
                snap[rr*3 +: 3] = sync_at(m_t - (3 - rr) * SD);
            scans.push_back(snap);
            run = 1;
            for (int j = scans.size() - 2; j >= 0; j--) begin
                if (scans[j] != snap) break;
                run++;
            end
            stable = (run > 15) ? 15 : run;
            if (stable == DB) begin
                if ($countones(snap) == 1 && !m_busy) begin
                    idx = 0;
                    for (int b = 0; b < 12; b++) if (snap[b]) idx = b;
                    m_busy = 1'b1;
`ifdef KEYPAD_CELL_ONLY_EN
                    if (idx < 9) begin
                        m_valid = 1'b1;
                        m_data = ref_code(idx);
                    end
`else
                    m_valid = 1'b1;
                    m_data = ref_code(idx);
`endif
                end else if (snap == 12'd0) begin
                    m_busy = 1'b0;
                end
            end
        end
        m_t++;
    endtask

    task automatic tick(input logic [2:0] col, input logic r);
        logic [9:0] exp_v, act_v;
        @(negedge clk);
        key_col = col;
        rst = r;
        @(posedge clk);
        model_step(col, r);
        #1;
        cyc++;
        exp_v = {4'(4'd1 << ((m_t / SD) % 4)), m_data, m_valid, m_busy};
        act_v = {key_row, key_data, key_valid, key_busy};
        n_vec++;
        if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL cycle %0d {row,data,valid,busy}: got %b expected %b", cyc, act_v, exp_v);
        end
        if (key_valid === 1'b1) begin
            phase_strobes++;
            if (have_strobe) check("strobe_gap_ok", (cyc - last_strobe) >= SCAN, 1);
            have_strobe = 1;
            last_strobe = cyc;
        end
    endtask

    function automatic logic [2:0] keys_col(input logic [11:0] mask);
        int rr;
        rr = (m_t / SD) % 4;
        return mask[rr*3 +: 3];
    endfunction

    task automatic hold(input logic [11:0] mask, input int ncyc);
        for (int i = 0; i < ncyc; i++) tick(keys_col(mask), 1'b0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 12'h020, 20, 1, 4'd6,  1'b1};
        tbl[1]  = '{1'b0, 12'h000, 1,  0, 4'd6,  1'b1};
        tbl[2]  = '{1'b0, 12'h000, 1,  0, 4'd6,  1'b0};
        tbl[3]  = '{1'b1, 12'h010, 4,  1, 4'd5,  1'b1};
        tbl[4]  = '{1'b0, 12'h000, 2,  0, 4'd5,  1'b0};
        tbl[5]  = '{1'b0, 12'h100, 4,  1, 4'd9,  1'b1};
        tbl[6]  = '{1'b0, 12'h000, 2,  0, 4'd9,  1'b0};
        tbl[7]  = '{1'b0, 12'h010, 4,  1, 4'd5,  1'b1};
        tbl[8]  = '{1'b0, 12'h000, 1,  0, 4'd5,  1'b1};
        tbl[9]  = '{1'b0, 12'h100, 4,  0, 4'd5,  1'b1};
        tbl[10] = '{1'b0, 12'h000, 3,  0, 4'd5,  1'b0};
        tbl[11] = '{1'b1, 12'h005, 6,  0, 4'hF,  1'b0};
`ifdef KEYPAD_CELL_ONLY_EN
        tbl[12] = '{1'b1, 12'h800, 4,  0, 4'hF,  1'b1};
        tbl[13] = '{1'b0, 12'h008, 4,  0, 4'hF,  1'b1};
        tbl[14] = '{1'b0, 12'h000, 2,  0, 4'hF,  1'b0};
`else
        tbl[12] = '{1'b1, 12'h800, 4,  1, 4'd11, 1'b1};
        tbl[13] = '{1'b0, 12'h008, 4,  0, 4'd11, 1'b1};
        tbl[14] = '{1'b0, 12'h000, 2,  0, 4'd11, 1'b0};
`endif
        tbl[15] = '{1'b0, 12'h008, 4,  1, 4'd4,  1'b1};

        // Reset state
        tick(3'd0, 1'b1);
        check("reset_row", key_row, 1);
        check("reset_data", key_data, 15);
        check("reset_valid", key_valid, 0);
        check("reset_busy", key_busy, 0);

        for (int k = 0; k < NT; k++) begin
            if (tbl[k].rst_first) tick(3'd0, 1'b1);
            phase_strobes = 0;
            hold(tbl[k].mask, tbl[k].scans * SCAN);
            check($sformatf("tbl%0d_strobes", k), phase_strobes, tbl[k].exp_strobes);
            check($sformatf("tbl%0d_data", k), key_data, tbl[k].exp_data);
            check($sformatf("tbl%0d_busy", k), key_busy, tbl[k].exp_busy);
        end

        // Bounce on column 1 for 5 scans, then a clean hold of cell 2
        tick(3'd0, 1'b1);
        phase_strobes = 0;
        for (int i = 0; i < 5 * SCAN; i++) tick(((i / 7) % 2 == 1) ? 3'b010 : 3'b000, 1'b0);
        check("bounce_strobes", phase_strobes, 0);
        phase_strobes = 0;
        hold(12'h002, 2 * SCAN);
        check("bounce_hold_strobes", phase_strobes, 1);
        check("bounce_hold_data", key_data, 2);
        check("bounce_hold_busy", key_busy, 1);

        // Reset in the middle of an accepted hold of cell 7
        tick(3'd0, 1'b1);
        phase_strobes = 0;
        hold(12'h040, 3 * SCAN);
        check("midrst_first_strobes", phase_strobes, 1);
        check("midrst_first_data", key_data, 7);
        tick(keys_col(12'h040), 1'b1);
        check("midrst_row", key_row, 1);
        check("midrst_data", key_data, 15);
        check("midrst_valid", key_valid, 0);
        check("midrst_busy", key_busy, 0);
        phase_strobes = 0;
        hold(12'h040, 2 * SCAN);
        check("midrst_again_strobes", phase_strobes, 1);
        check("midrst_again_data", key_data, 7);
        check("midrst_again_busy", key_busy, 1);

        // Randomized keypad activity checked cycle by cycle against the model
        tick(3'd0, 1'b1);
        for (int s = 0; s < 80; s++) begin
            int kind, len;
            logic [11:0] m;
            kind = $urandom_range(0, 19);
            len = $urandom_range(1, 60);
            if (kind == 19) begin
                tick(3'd0, 1'b1);
            end else if (kind == 18) begin
                for (int i = 0; i < len; i++) tick(3'($urandom_range(0, 7)), 1'b0);
            end else if (kind >= 15) begin
                m = 12'd0;
                m[$urandom_range(0, 11)] = 1'b1;
                m[$urandom_range(0, 11)] = 1'b1;
                hold(m, len);
            end else if (kind >= 10) begin
                hold(12'd0, len + SCAN * 2);
            end else begin
                m = 12'd0;
                m[$urandom_range(0, 11)] = 1'b1;
                hold(m, len + SCAN * $urandom_range(0, 3));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
